bcd_display_scanner: RTL



---
 rtl/display_pkg.sv | 19 +
 rtl/scan_slot_timer.sv | 64 ++++++
 rtl/bcd_display_scanner.sv | 83 ++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed BCD display scanner.
package display_pkg;

    localparam int N_DIGITS = 4;
    localparam int IDX_W    = 2;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    function automatic logic [3:0] nibble_sel(
        input logic [4*N_DIGITS-1:0] value,
        input logic [IDX_W-1:0]      idx
    );
        return value[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Slot timer: counts cycles within a digit slot, steps the digit index and
// runs the BLANK/SHOW state machine that gates the digit enables.
module scan_slot_timer
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 12500,
    parameter int BLANK_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx,
    output logic             in_show,
    output logic             slot_wrap,
    output logic             show_start,
    output logic             frame_start
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SHOW_M1 = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    scan_state_t      state;
    scan_state_t      next_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= '0;
            state <= BLANK;
        end else begin
            state <= next_state;
            if (slot_wrap) begin
                cnt <= '0;
                idx <= idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // show_start marks the edge that loads the output registers for this slot.
    always_comb begin
        next_state = state;
        show_start = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == CNT_SHOW_M1) begin
                    next_state = SHOW;
                    show_start = 1'b1;
                end
            end
            SHOW: begin
                if (slot_wrap) next_state = BLANK;
            end
            default: next_state = BLANK;
        endcase
    end

    assign slot_wrap   = (cnt == CNT_LAST);
    assign in_show     = (state == SHOW);
    assign frame_start = (state == BLANK) && (idx == '0) && (cnt == '0);

endmodule

// File: rtl/bcd_display_scanner.sv
// Four-digit multiplexed feeder for a single BCD-to-7-segment decoder, with
// inter-digit blanking, leading-zero blanking and a per-frame input snapshot.
module bcd_display_scanner
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 12500,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lzb_en,
    output logic [3:0]            bcd_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   digit_en,
    output logic                  frame_start
);

    logic [IDX_W-1:0]      idx;
    logic                  in_show;
    logic                  slot_wrap;
    logic                  show_start;
    logic [4*N_DIGITS-1:0] snap_bcd;
    logic [N_DIGITS-1:0]   snap_dp;
    logic [4*N_DIGITS-1:0] eff_bcd;
    logic [N_DIGITS-1:0]   eff_dp;
    logic [N_DIGITS-1:0]   suppress;
    logic                  zero_run;

    scan_slot_timer #(
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx),
        .in_show    (in_show),
        .slot_wrap  (slot_wrap),
        .show_start (show_start),
        .frame_start(frame_start)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_bcd <= '0;
            snap_dp  <= '0;
        end else if (frame_start) begin
            snap_bcd <= bcd_in;
            snap_dp  <= dp_in;
        end
    end

    // Bypass during the capture cycle so digit 0 is correct even when the
    // SHOW entry edge coincides with the snapshot edge (BLANK_CYCLES == 1).
    assign eff_bcd = frame_start ? bcd_in : snap_bcd;
    assign eff_dp  = frame_start ? dp_in  : snap_dp;

    // A digit is blank while it and every higher digit are zero without a dp.
    always_comb begin
        suppress = '0;
        zero_run = lzb_en;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run && (nibble_sel(eff_bcd, IDX_W'(i)) == 4'h0) && !eff_dp[i];
            suppress[i] = zero_run;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_out  <= '0;
            dp_out   <= 1'b0;
            digit_en <= '0;
        end else if (show_start) begin
            bcd_out  <= nibble_sel(eff_bcd, idx);
            dp_out   <= eff_dp[idx];
            digit_en <= suppress[idx] ? '0 : (N_DIGITS'(1) << idx);
        end else if (slot_wrap && in_show) begin
            digit_en <= '0;
        end
    end

endmodule
